// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master sequencer and its address decoder.
package apb_pkg;

   localparam logic [15:0] APB_BASE_HI = 16'h1000;
   localparam int          IDX_W       = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_ERR
   } apb_state_e;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational peripheral decode: upper address bits select one of NUM_SLV 4 KiB windows.
module apb_addr_decoder
   import apb_pkg::*;
#(
   parameter int NUM_SLV = 4
) (
   input  logic [19:0]      i_addr_hi,
   output logic             o_hit,
   output logic [IDX_W-1:0] o_idx
);

   assign o_idx = i_addr_hi[3:0];
   assign o_hit = (i_addr_hi[19:4] == APB_BASE_HI) && (int'(o_idx) < NUM_SLV);

endmodule

// File: rtl/apb_master_ctrl.sv
// Core-side request to APB SETUP/ACCESS sequencer with address decode and PREADY timeout.
module apb_master_ctrl
   import apb_pkg::*;
#(
   parameter int NUM_SLV = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_transfer,
   input  logic                     i_write,
   input  logic [31:0]              i_addr,
   input  logic [31:0]              i_wdata,
   output logic [31:0]              o_rdata,
   output logic                     o_ready,
   output logic                     o_err,
   output logic [31:0]              o_paddr,
   output logic                     o_pwrite,
   output logic [31:0]              o_pwdata,
   output logic                     o_penable,
   output logic [NUM_SLV-1:0]       o_psel,
   input  logic [NUM_SLV-1:0][31:0] i_prdata,
   input  logic [NUM_SLV-1:0]       i_pready
);

   localparam int               CNT_W   = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   apb_state_e         r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [NUM_SLV-1:0] r_psel;
   logic               r_penable;
   logic [31:0]        r_paddr;
   logic               r_pwrite;
   logic [31:0]        r_pwdata;

   logic               w_hit;
   logic [IDX_W-1:0]   w_idx;
   logic [NUM_SLV-1:0] w_sel_onehot;
   logic               w_pready_sel;
   logic [31:0]        w_prdata_sel;
   logic               w_in_access;
   logic               w_timeout;

   apb_addr_decoder #(.NUM_SLV(NUM_SLV)) u_dec (
      .i_addr_hi (i_addr[31:12]),
      .o_hit     (w_hit),
      .o_idx     (w_idx)
   );

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_sel_onehot = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (w_idx == IDX_W'(i)) w_sel_onehot[i] = 1'b1;
      end
   end

   // r_psel is one-hot (or zero), so OR-reducing the masked slave buses selects the active slave.
   always_comb begin
      w_pready_sel = 1'b0;
      w_prdata_sel = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (r_psel[i]) begin
            w_pready_sel = w_pready_sel | i_pready[i];
            w_prdata_sel = w_prdata_sel | i_prdata[i];
         end
      end
   end

   assign w_in_access = (r_state == ST_ACCESS);
   assign w_timeout   = (r_cnt == CNT_MAX);

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_psel    <= '0;
         r_penable <= 1'b0;
         r_paddr   <= '0;
         r_pwrite  <= 1'b0;
         r_pwdata  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_transfer) begin
                  if (w_hit) begin
                     r_paddr  <= i_addr;
                     r_pwrite <= i_write;
                     r_pwdata <= i_wdata;
                     r_psel   <= w_sel_onehot;
                     r_state  <= ST_SETUP;
                  end else begin
                     r_state  <= ST_ERR;
                  end
               end
            end
            ST_SETUP: begin
               r_cnt     <= '0;
               r_penable <= 1'b1;
               r_state   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (w_pready_sel || w_timeout) begin
                  r_psel    <= '0;
                  r_penable <= 1'b0;
                  r_state   <= ST_IDLE;
               end else if (r_cnt != CNT_MAX) begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_ERR:  r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Completion is combinational on PREADY; a reset in flight suppresses the strobe.
   assign o_ready = !i_reset && ((w_in_access && (w_pready_sel || w_timeout)) || (r_state == ST_ERR));
   assign o_err   = !i_reset && ((w_in_access && !w_pready_sel && w_timeout) || (r_state == ST_ERR));
   assign o_rdata = (!i_reset && w_in_access && w_pready_sel && !r_pwrite) ? w_prdata_sel : 32'h0;

   assign o_psel    = r_psel;
   assign o_penable = r_penable;
   assign o_paddr   = r_paddr;
   assign o_pwrite  = r_pwrite;
   assign o_pwdata  = r_pwdata;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: inputs driven on the falling edge, outputs checked 1 ns later.
module tb_apb_master_ctrl;

   localparam int NUM_SLV = 4;
   localparam int TIMEOUT = 16;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     transfer;
   logic                     write;
   logic [31:0]              addr;
   logic [31:0]              wdata;
   logic [31:0]              rdata;
   logic                     ready;
   logic                     err;
   logic [31:0]              paddr;
   logic                     pwrite;
   logic [31:0]              pwdata;
   logic                     penable;
   logic [NUM_SLV-1:0]       psel;
   logic [NUM_SLV-1:0][31:0] prdata;
   logic [NUM_SLV-1:0]       pready;

   // {psel, penable, ready, err}
   logic [6:0] ctl;
   assign ctl = {psel, penable, ready, err};

   int pass_cnt  = 0;
   int total_cnt = 0;

   apb_master_ctrl #(.NUM_SLV(NUM_SLV), .TIMEOUT(TIMEOUT)) dut (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_transfer (transfer),
      .i_write    (write),
      .i_addr     (addr),
      .i_wdata    (wdata),
      .o_rdata    (rdata),
      .o_ready    (ready),
      .o_err      (err),
      .o_paddr    (paddr),
      .o_pwrite   (pwrite),
      .o_pwdata   (pwdata),
      .o_penable  (penable),
      .o_psel     (psel),
      .i_prdata   (prdata),
      .i_pready   (pready)
   );

   always #5 clk = ~clk;

   task automatic clear_req();
      transfer = 1'b0;
      write    = 1'b0;
      addr     = 32'h0;
      wdata    = 32'h0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_req();
      pready = '0;
      prdata = '0;
      repeat (2) @(negedge clk);
      #1;
      total_cnt++;
      if (ctl !== 7'b0) $display("FAIL reset_ctl got=%b exp=%b", ctl, 7'b0);
      else pass_cnt++;
      total_cnt++;
      if ({pwrite, paddr, pwdata, rdata} !== 97'b0)
         $display("FAIL reset_bus got pw=%b pa=%h pd=%h rd=%h exp all 0", pwrite, paddr, pwdata, rdata);
      else pass_cnt++;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_write_zero_wait();
      @(negedge clk);
      transfer = 1'b1; write = 1'b1; addr = 32'h1000_2004; wdata = 32'hDEAD_BEEF;
      pready = 4'b0100;
      #1;
      total_cnt++;
      if (ctl !== 7'b0000_000) $display("FAIL wr_c0 got=%b exp=%b", ctl, 7'b0000_000);
      else pass_cnt++;
      @(negedge clk);
      clear_req();
      #1;
      total_cnt++;
      if (ctl !== 7'b0100_000) $display("FAIL wr_setup got=%b exp=%b", ctl, 7'b0100_000);
      else pass_cnt++;
      total_cnt++;
      if ({pwrite, paddr, pwdata} !== {1'b1, 32'h1000_2004, 32'hDEAD_BEEF})
         $display("FAIL wr_setup_bus got pw=%b pa=%h pd=%h exp pw=1 pa=10002004 pd=deadbeef", pwrite, paddr, pwdata);
      else pass_cnt++;
      @(negedge clk);
      #1;
      total_cnt++;
      if (ctl !== 7'b0100_110) $display("FAIL wr_access got=%b exp=%b", ctl, 7'b0100_110);
      else pass_cnt++;
      total_cnt++;
      if ({rdata, pwdata} !== {32'h0, 32'hDEAD_BEEF})
         $display("FAIL wr_access_data got rd=%h pd=%h exp rd=0 pd=deadbeef", rdata, pwdata);
      else pass_cnt++;
      @(negedge clk);
      pready = '0;
      #1;
      total_cnt++;
      if ({ctl, paddr} !== {7'b0, 32'h1000_2004})
         $display("FAIL wr_done_hold got ctl=%b pa=%h exp ctl=0 pa=10002004", ctl, paddr);
      else pass_cnt++;
   endtask

   task automatic test_read_wait();
      @(negedge clk);
      transfer = 1'b1; write = 1'b0; addr = 32'h1000_1000;
      prdata[1] = 32'h1234_5678;
      prdata[0] = 32'hFFFF_0000;
      #1;
      @(negedge clk);
      clear_req();
      #1;
      total_cnt++;
      if (ctl !== 7'b0010_000) $display("FAIL rd_setup got=%b exp=%b", ctl, 7'b0010_000);
      else pass_cnt++;
      // Three wait states; a non-selected slave's PREADY must be ignored.
      for (int c = 2; c <= 4; c++) begin
         @(negedge clk);
         pready = 4'b0001;
         #1;
         total_cnt++;
         if (ctl !== 7'b0010_100) $display("FAIL rd_wait%0d got=%b exp=%b", c, ctl, 7'b0010_100);
         else pass_cnt++;
      end
      @(negedge clk);
      pready = 4'b0010;
      #1;
      total_cnt++;
      if ({ctl, rdata} !== {7'b0010_110, 32'h1234_5678})
         $display("FAIL rd_ready got ctl=%b rd=%h exp ctl=0010110 rd=12345678", ctl, rdata);
      else pass_cnt++;
      @(negedge clk);
      pready = '0;
      #1;
      total_cnt++;
      if ({ctl, rdata} !== {7'b0, 32'h0}) $display("FAIL rd_done got ctl=%b rd=%h exp 0", ctl, rdata);
      else pass_cnt++;
   endtask

   task automatic test_unmapped();
      logic [31:0] bad_addr [2];
      bad_addr[0] = 32'h2000_0000;
      bad_addr[1] = 32'h1000_4000;   // window index equal to NUM_SLV
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         transfer = 1'b1; write = 1'b0; addr = bad_addr[k];
         pready = 4'b1111;
         #1;
         @(negedge clk);
         clear_req();
         #1;
         total_cnt++;
         if ({ctl, rdata} !== {7'b0000_011, 32'h0})
            $display("FAIL unmapped%0d got ctl=%b rd=%h exp ctl=0000011 rd=0", k, ctl, rdata);
         else pass_cnt++;
         @(negedge clk);
         pready = '0;
         #1;
         total_cnt++;
         if (ctl !== 7'b0) $display("FAIL unmapped%0d_after got=%b exp=%b", k, ctl, 7'b0);
         else pass_cnt++;
      end
   endtask

   // late_pready=1 raises PREADY exactly on the limit cycle, which must complete without error.
   task automatic test_timeout(input bit late_pready);
      @(negedge clk);
      transfer = 1'b1; write = 1'b0; addr = 32'h1000_0010;
      prdata[0] = 32'hAAAA_5555;
      pready = '0;
      #1;
      @(negedge clk);
      clear_req();
      #1;
      for (int c = 2; c <= TIMEOUT; c++) begin
         @(negedge clk);
         #1;
         total_cnt++;
         if (ctl !== 7'b0001_100) $display("FAIL to_wait%0d got=%b exp=%b", c, ctl, 7'b0001_100);
         else pass_cnt++;
      end
      @(negedge clk);
      if (late_pready) pready = 4'b0001;
      #1;
      total_cnt++;
      if (late_pready) begin
         if ({ctl, rdata} !== {7'b0001_110, 32'hAAAA_5555})
            $display("FAIL to_edge_ok got ctl=%b rd=%h exp ctl=0001110 rd=aaaa5555", ctl, rdata);
         else pass_cnt++;
      end else begin
         if ({ctl, rdata} !== {7'b0001_111, 32'h0})
            $display("FAIL to_err got ctl=%b rd=%h exp ctl=0001111 rd=0", ctl, rdata);
         else pass_cnt++;
      end
      @(negedge clk);
      pready = '0;
      #1;
      total_cnt++;
      if (ctl !== 7'b0) $display("FAIL to_after got=%b exp=%b", ctl, 7'b0);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      transfer = 1'b1; write = 1'b0; addr = 32'h1000_1010;
      pready = '0;
      #1;
      repeat (3) @(negedge clk);
      clear_req();
      reset = 1'b1;
      #1;
      total_cnt++;
      if (ctl !== 7'b0010_100) $display("FAIL rst_mid_pre got=%b exp=%b", ctl, 7'b0010_100);
      else pass_cnt++;
      @(negedge clk);
      reset = 1'b0;
      #1;
      total_cnt++;
      if ({ctl, paddr} !== {7'b0, 32'h0}) $display("FAIL rst_mid_post got ctl=%b pa=%h exp 0", ctl, paddr);
      else pass_cnt++;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         #1;
         total_cnt++;
         if (ctl !== 7'b0) $display("FAIL rst_mid_quiet%0d got=%b exp=%b", c, ctl, 7'b0);
         else pass_cnt++;
      end
      @(negedge clk);
      transfer = 1'b1; write = 1'b1; addr = 32'h1000_1008; wdata = 32'h1111_2222;
      pready = 4'b0010;
      #1;
      @(negedge clk);
      clear_req();
      #1;
      total_cnt++;
      if (ctl !== 7'b0010_000) $display("FAIL rst_new_setup got=%b exp=%b", ctl, 7'b0010_000);
      else pass_cnt++;
      @(negedge clk);
      #1;
      total_cnt++;
      if ({ctl, pwdata} !== {7'b0010_110, 32'h1111_2222})
         $display("FAIL rst_new_done got ctl=%b pd=%h exp ctl=0010110 pd=11112222", ctl, pwdata);
      else pass_cnt++;
      @(negedge clk);
      pready = '0;
   endtask

   task automatic test_ignored();
      @(negedge clk);
      transfer = 1'b1; write = 1'b0; addr = 32'h1000_0000;
      prdata[0] = 32'hCAFE_F00D;
      pready = '0;
      #1;
      @(negedge clk);
      clear_req();
      #1;
      @(negedge clk);
      transfer = 1'b1; write = 1'b1; addr = 32'h1000_3000; wdata = 32'h5555_5555;
      #1;
      total_cnt++;
      if (ctl !== 7'b0001_100) $display("FAIL ign_access got=%b exp=%b", ctl, 7'b0001_100);
      else pass_cnt++;
      @(negedge clk);
      clear_req();
      #1;
      total_cnt++;
      if (ctl !== 7'b0001_100) $display("FAIL ign_wait got=%b exp=%b", ctl, 7'b0001_100);
      else pass_cnt++;
      @(negedge clk);
      pready = 4'b0001;
      #1;
      total_cnt++;
      if ({ctl, rdata} !== {7'b0001_110, 32'hCAFE_F00D})
         $display("FAIL ign_done got ctl=%b rd=%h exp ctl=0001110 rd=cafef00d", ctl, rdata);
      else pass_cnt++;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         pready = '0;
         #1;
         total_cnt++;
         if (ctl !== 7'b0) $display("FAIL ign_after%0d got=%b exp=%b", c, ctl, 7'b0);
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      transfer = 1'b1; write = 1'b1; addr = 32'h1000_3FFC; wdata = 32'h0F0F_0F0F;
      pready = 4'b1000;
      #1;
      @(negedge clk);
      clear_req();
      #1;
      total_cnt++;
      if ({ctl, paddr} !== {7'b1000_000, 32'h1000_3FFC})
         $display("FAIL b2b_setup got ctl=%b pa=%h exp ctl=1000000 pa=10003ffc", ctl, paddr);
      else pass_cnt++;
      // A request arriving with ready falls outside IDLE and is dropped.
      @(negedge clk);
      transfer = 1'b1; write = 1'b0; addr = 32'h3000_0000;
      #1;
      total_cnt++;
      if (ctl !== 7'b1000_110) $display("FAIL b2b_first got=%b exp=%b", ctl, 7'b1000_110);
      else pass_cnt++;
      @(negedge clk);
      transfer = 1'b1; write = 1'b0; addr = 32'h1000_1000;
      prdata[1] = 32'h0BAD_CAFE;
      pready = 4'b0010;
      #1;
      total_cnt++;
      if (ctl !== 7'b0) $display("FAIL b2b_gap got=%b exp=%b", ctl, 7'b0);
      else pass_cnt++;
      @(negedge clk);
      clear_req();
      #1;
      total_cnt++;
      if (ctl !== 7'b0010_000) $display("FAIL b2b_setup2 got=%b exp=%b", ctl, 7'b0010_000);
      else pass_cnt++;
      @(negedge clk);
      #1;
      total_cnt++;
      if ({ctl, rdata} !== {7'b0010_110, 32'h0BAD_CAFE})
         $display("FAIL b2b_second got ctl=%b rd=%h exp ctl=0010110 rd=0badcafe", ctl, rdata);
      else pass_cnt++;
      @(negedge clk);
      pready = '0;
   endtask

   initial begin
      test_reset();
      test_write_zero_wait();
      test_read_wait();
      test_unmapped();
      test_timeout(1'b0);
      test_timeout(1'b1);
      test_reset_mid();
      test_ignored();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/apb_master_ctrl.md
# apb_master_ctrl

Bus-transfer sequencer between the RV32I core's data bus and the APB peripheral fabric. It takes a one-cycle transfer request from the core side, decodes the address to one of `NUM_SLV` peripherals, and drives a compliant APB SETUP/ACCESS sequence. It returns read data with a `ready` strobe, and flags unmapped addresses and slave timeouts with `err`. It sits beside data RAM in the system top; the core stalls on `!ready` while a peripheral access is pending.

## Interface
- `NUM_SLV`, 4: number of APB slaves (1..16).
- `TIMEOUT`, 16: maximum ACCESS-phase cycles waiting for PREADY before error completion (≥2).
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `transfer` in 1: one-cycle request pulse; sampled only in IDLE.
- `write` in 1: 1 = write, 0 = read; qualified by `transfer`.
- `addr` in 32: byte address; qualified by `transfer`.
- `wdata` in 32: write data; qualified by `transfer`.
- `rdata` out 32: read data; valid only when `ready && !err && !write_q`, otherwise 0.
- `ready` out 1: one-cycle completion strobe.
- `err` out 1: asserted with `ready` on an unmapped address or a timeout.
- `PADDR` out 32, `PWRITE` out 1, `PWDATA` out 32, `PENABLE` out 1: APB master signals.
- `PSEL` out NUM_SLV: one-hot slave select.
- `PRDATA` in NUM_SLV×32: per-slave read data.
- `PREADY` in NUM_SLV: per-slave ready.

## Operation
- **Decode:** slave i is hit when `addr[31:16]==16'h1000` and `addr[15:12]==i`, for i<NUM_SLV; any other address is unmapped.
- **States:** IDLE, SETUP, ACCESS, ERR.
- **IDLE:**
  - `transfer` with a mapped address: latch addr, write, wdata and slave index; go to SETUP.
  - `transfer` with an unmapped address: go to ERR.
  - Otherwise stay in IDLE.
- **SETUP:** `PSEL[idx]=1`, `PENABLE=0`, PADDR/PWRITE/PWDATA from the latches; unconditionally go to ACCESS. Clear the timeout counter.
- **ACCESS:** `PSEL[idx]=1`, `PENABLE=1`. The counter increments each cycle.
  - `PREADY[idx]=1`: `ready=1`, `rdata=PRDATA[idx]` (combinational, reads only); go to IDLE.
  - Counter reaches TIMEOUT-1 with PREADY still low: `ready=1`, `err=1`, `rdata=0`; go to IDLE.
- **ERR:** `ready=1`, `err=1`, no PSEL; go to IDLE.
- `transfer` outside IDLE is ignored; only one transfer is ever outstanding.
- PADDR, PWRITE and PWDATA hold their last latched values in IDLE.
- PREADY from non-selected slaves is ignored.
- Counter width is `$clog2(TIMEOUT)`. The counter saturates and never wraps inside ACCESS.

## Timing
- **Reset:** state=IDLE, counter=0, and every output is 0: PSEL, PENABLE, PADDR, PWRITE, PWDATA, ready, err, rdata.
- **Reset mid-transfer:** PSEL and PENABLE are 0 from the next edge. No `ready` is issued, and the pending request is dropped.
- **Minimum mapped latency:** `transfer` at cycle 0 → SETUP at cycle 1 → ACCESS with `ready` at cycle 2 (PREADY held high).
- **Slave wait states:** each cycle of PREADY low extends ACCESS by one cycle.
- **Timeout:** `ready`+`err` occurs in the TIMEOUT-th ACCESS cycle, i.e. cycle 1+TIMEOUT after `transfer`.
- **Unmapped latency:** `ready`+`err` at cycle 1.
- **Back-to-back:** the earliest next accepted `transfer` is the cycle after `ready`, in IDLE.
- **PREADY on the timeout cycle:** PREADY=1 in the same cycle the counter hits its limit counts as success (`err=0`).

## Structure
- `apb_pkg`: state enum (IDLE/SETUP/ACCESS/ERR), `APB_BASE_HI=16'h1000`, slave-index width constant.
- Sub-module `apb_addr_decoder`: combinational; addr → `{hit, idx}`. The FSM and timeout counter stay in `apb_master_ctrl`.

## Test plan
- **Write, zero-wait:** `transfer`, `write=1`, `addr=0x1000_2004`, `wdata=0xDEAD_BEEF`; slave 2 PREADY=1 → PSEL=4'b0100 at cycle 1 (PENABLE=0), PENABLE=1 at cycle 2, `ready=1`, `err=0`, PWDATA=0xDEADBEEF.
- **Read, 3 wait states:** read `0x1000_1000`; PRDATA[1]=0x1234_5678, PREADY rising at the 4th ACCESS cycle → `ready` at cycle 5, `rdata=0x12345678`.
- **Unmapped:** read `0x2000_0000` → `ready=1`, `err=1` at cycle 1; PSEL stays 0 throughout.
- **Timeout (TIMEOUT=16):** PREADY held low → `ready=1`, `err=1`, `rdata=0` at cycle 17; PSEL=0 at cycle 18.
- **Reset in ACCESS:** `reset` asserted during a wait state → PSEL, PENABLE and ready all 0 at the next edge, no `ready` pulse, and a new transfer after reset completes normally.
- **Ignored request:** a `transfer` pulse with `addr=0x1000_3000` during an ACCESS to slave 0 → PSEL[3] never asserts; only the original transfer completes.
